// File: rtl/car_nco_gen_if.sv
// Carrier NCO control and sample bus: control and offset toward the NCO,
// I/Q samples, valid, wrap tick and accumulator monitor back.
interface car_nco_gen_if #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 8
);
    logic                      rx_en;
    logic                      rx_fcw_load;
    logic [PHASE_W-1:0]        rx_car_fcw;
    logic [PHASE_W-1:0]        rx_phs_ofs;
    logic                      rx_phs_clr;
    logic signed [DATA_W-1:0]  tx_car_cos;
    logic signed [DATA_W-1:0]  tx_car_sin;
    logic                      tx_car_valid;
    logic                      tx_car_wrap;
    logic [PHASE_W-1:0]        phs_acc_reg;

    modport master (
        output rx_en, rx_fcw_load, rx_car_fcw, rx_phs_ofs, rx_phs_clr,
        input  tx_car_cos, tx_car_sin, tx_car_valid, tx_car_wrap, phs_acc_reg
    );

    modport slave (
        input  rx_en, rx_fcw_load, rx_car_fcw, rx_phs_ofs, rx_phs_clr,
        output tx_car_cos, tx_car_sin, tx_car_valid, tx_car_wrap, phs_acc_reg
    );
endinterface

// File: rtl/car_nco_gen.sv
// Carrier NCO: phase accumulator with shadowed FCW, phase offset, and a
// registered full-cycle cosine table read twice (I at phase, Q at phase+270 deg).
module car_nco_gen #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic          rx_clk,
    input  logic          rx_rst,
    car_nco_gen_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SIN_SHIFT = ADDR_W'(3 * (DEPTH / 4));

    // Table entry k = round(A*cos(2*pi*k/DEPTH)), evaluated at elaboration.
    function automatic logic signed [DATA_W-1:0] cos_entry(input int k);
        real amp;
        real x;
        int  r;
        amp = real'((2 ** (DATA_W - 1)) - 1);
        x   = amp * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH));
        if (x >= 0.0) begin
            r = $rtoi(x + 0.5);
        end else begin
            r = -$rtoi(0.5 - x);
        end
        return DATA_W'(r);
    endfunction

    logic signed [DATA_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic signed [DATA_W-1:0] ENTRY = cos_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [PHASE_W-1:0]       acc_q, acc_d;
    logic [PHASE_W-1:0]       fcw_q, fcw_d;
    logic                     wrap_q, wrap_d;
    logic                     v0_q, v0_d;
    logic [ADDR_W-1:0]        addr_cos_q, addr_cos_d;
    logic [ADDR_W-1:0]        addr_sin_q, addr_sin_d;
    logic                     v1_q, v1_d;
    logic signed [DATA_W-1:0] cos_q, cos_d;
    logic signed [DATA_W-1:0] sin_q, sin_d;
    logic                     valid_q, valid_d;
    logic [PHASE_W:0]         step_sum_s;
    logic [PHASE_W-1:0]       ofs_sum_s;

    // Next-state for accumulator, FCW shadow, address stage and table read stage.
    always_comb begin
        acc_d      = acc_q;
        fcw_d      = fcw_q;
        wrap_d     = 1'b0;
        v0_d       = 1'b0;
        step_sum_s = {1'b0, acc_q} + {1'b0, fcw_q};
        ofs_sum_s  = acc_q + bus.rx_phs_ofs;

        if (bus.rx_fcw_load) begin
            fcw_d = bus.rx_car_fcw;
        end else begin
            fcw_d = fcw_q;
        end

        if (bus.rx_phs_clr) begin
            acc_d = '0;
        end else if (bus.rx_en) begin
            acc_d  = step_sum_s[PHASE_W-1:0];
            wrap_d = step_sum_s[PHASE_W];
            v0_d   = 1'b1;
        end else begin
            acc_d = acc_q;
        end

        addr_cos_d = ofs_sum_s[PHASE_W-1 -: ADDR_W];
        addr_sin_d = addr_cos_d + SIN_SHIFT;
        v1_d       = v0_q;
        cos_d      = rom[addr_cos_q];
        sin_d      = rom[addr_sin_q];
        valid_d    = v1_q;
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            acc_q      <= '1;
            fcw_q      <= '0;
            wrap_q     <= 1'b0;
            v0_q       <= 1'b0;
            addr_cos_q <= '0;
            addr_sin_q <= '0;
            v1_q       <= 1'b0;
            cos_q      <= '0;
            sin_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fcw_q      <= fcw_d;
            wrap_q     <= wrap_d;
            v0_q       <= v0_d;
            addr_cos_q <= addr_cos_d;
            addr_sin_q <= addr_sin_d;
            v1_q       <= v1_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.tx_car_cos   = cos_q;
    assign bus.tx_car_sin   = sin_q;
    assign bus.tx_car_valid = valid_q;
    assign bus.tx_car_wrap  = wrap_q;
    assign bus.phs_acc_reg  = acc_q;
endmodule

// File: tb/tb_car_nco_gen.sv
// Bench for car_nco_gen: directed steps checked against a phase model,
// with I/Q samples queued at address capture and compared by a monitor.
module tb_car_nco_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    car_nco_gen_if #(.PHASE_W(32), .DATA_W(8)) bus ();

    car_nco_gen #(.PHASE_W(32), .ADDR_W(8), .DATA_W(8)) dut (
        .rx_clk (clk),
        .rx_rst (rst),
        .bus    (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    logic [31:0] m_acc;
    logic [31:0] m_fcw;
    logic        m_wrap;
    logic        m_v0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rom_model(input logic [7:0] a);
        real x;
        int  r;
        x = 127.0 * $cos(2.0 * 3.141592653589793 * real'(int'(a)) / 256.0);
        if (x >= 0.0) r = $rtoi(x + 0.5);
        else          r = -$rtoi(0.5 - x);
        return r[7:0];
    endfunction

    task automatic step(input logic en, input logic load, input logic [31:0] fcw,
                        input logic clr, input logic [31:0] ofs);
        logic [32:0] s;
        logic [31:0] sa;
        logic [7:0]  ac;
        logic [7:0]  as;
        bus.rx_en       = en;
        bus.rx_fcw_load = load;
        bus.rx_car_fcw  = fcw;
        bus.rx_phs_clr  = clr;
        bus.rx_phs_ofs  = ofs;
        if (m_v0) begin
            sa = m_acc + ofs;
            ac = sa[31:24];
            as = ac + 8'hC0;
            exp_q.push_back({rom_model(ac), rom_model(as)});
        end
        @(posedge clk);
        #1;
        if (clr) begin
            m_acc  = 32'h0;
            m_wrap = 1'b0;
            m_v0   = 1'b0;
        end else if (en) begin
            s      = {1'b0, m_acc} + {1'b0, m_fcw};
            m_acc  = s[31:0];
            m_wrap = s[32];
            m_v0   = 1'b1;
        end else begin
            m_wrap = 1'b0;
            m_v0   = 1'b0;
        end
        if (load) m_fcw = fcw;
        check("acc", bus.phs_acc_reg, m_acc);
        check("wrap", {31'b0, bus.tx_car_wrap}, {31'b0, m_wrap});
    endtask

    task automatic do_reset();
        bus.rx_en       = 1'b0;
        bus.rx_fcw_load = 1'b0;
        bus.rx_car_fcw  = 32'h0;
        bus.rx_phs_clr  = 1'b0;
        bus.rx_phs_ofs  = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        m_acc  = 32'hFFFF_FFFF;
        m_fcw  = 32'h0;
        m_wrap = 1'b0;
        m_v0   = 1'b0;
        check("rst_acc", bus.phs_acc_reg, 32'hFFFF_FFFF);
        check("rst_cos", {24'b0, bus.tx_car_cos}, 32'h0);
        check("rst_sin", {24'b0, bus.tx_car_sin}, 32'h0);
        check("rst_valid", {31'b0, bus.tx_car_valid}, 32'h0);
        check("rst_wrap", {31'b0, bus.tx_car_wrap}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic drain(input logic [31:0] ofs);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, ofs);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: every presented sample must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [15:0] e;
        if (bus.tx_car_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=cos %h sin %h required=no sample",
                         bus.tx_car_cos, bus.tx_car_sin);
            end else begin
                e = exp_q.pop_front();
                check("cos", {24'b0, bus.tx_car_cos}, {24'b0, e[15:8]});
                check("sin", {24'b0, bus.tx_car_sin}, {24'b0, e[7:0]});
            end
        end
    end

    initial begin
        m_acc  = 32'hFFFF_FFFF;
        m_fcw  = 32'h0;
        m_wrap = 1'b0;
        m_v0   = 1'b0;
        do_reset();

        // Load 0x01000000 then run: first step wraps to 0x00FFFFFF.
        step(1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_first_acc", bus.phs_acc_reg, 32'h00FF_FFFF);
        check("t2_first_wrap", {31'b0, bus.tx_car_wrap}, 32'h1);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // FCW change mid-run: load edge still uses the old word.
        step(1'b1, 1'b1, 32'h0200_0000, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Phase clear while running, then +90 deg offset.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h4000_0000);
        check("t4_clr_acc", bus.phs_acc_reg, 32'h0);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h4000_0000);

        // Enable pattern 1,0,0,1 holds phase; valid trails by two cycles.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drain(32'h0);

        // Half-rate carrier from zero phase, with clear and load together.
        step(1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h0);
        check("t6_clr_load_acc", bus.phs_acc_reg, 32'h0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.rx_en = 1'b1;
        do_reset();
        drain(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
